// File: rtl/pll_cen_gen.sv
// Multi-channel fractional clock-enable generator gated by a settled PLL lock.
// Optional feature macro: PLL_CEN_PAUSE_EN (pause freezes accumulators in RUN).
module pll_cen_gen #(
  parameter int               NCH       = 4,
  parameter int               CH_W      = 2,
  parameter int               ACC_W     = 16,
  parameter int               LOCK_WAIT = 1024,
  parameter logic [ACC_W-1:0] INC_RST   = 16'h2000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic             pause,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             run,
  output logic [NCH-1:0]   cen
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  localparam int             CNT_W    = $clog2(LOCK_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_WAIT - 1);

  logic             lk_meta_r;
  logic             lk_s_r;
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             cfg_ready_r;
  logic [ACC_W-1:0] acc_r    [NCH];
  logic [ACC_W-1:0] inc_r    [NCH];
  logic [ACC_W-1:0] shadow_r [NCH];
  logic [ACC_W:0]   sum_s    [NCH];
  logic [NCH-1:0]   pend_r;
  logic [NCH-1:0]   cen_r;
  logic [NCH-1:0]   carry_s;
  logic [NCH-1:0]   apply_s;
  logic             pause_s;
  logic             run_st_s;
  logic             active_s;
  logic             hold_s;
  logic             accept_s;
  logic             ch_ok_s;

`ifdef PLL_CEN_PAUSE_EN
  assign pause_s = pause;
`else
  logic unused_pause_s;
  assign unused_pause_s = pause;
  assign pause_s        = 1'b0;
`endif

  assign run_st_s  = (state_r == ST_RUN);
  // The synchronised lock term suppresses a carry landing in the lock-loss cycle.
  assign active_s  = run_st_s & lk_s_r & ~pause_s;
  assign hold_s    = run_st_s & lk_s_r & pause_s;
  assign accept_s  = cfg_valid & cfg_ready_r;
  assign ch_ok_s   = (int'(cfg_ch) < NCH);
  assign cfg_ready = cfg_ready_r;
  assign run       = run_r;
  assign cen       = cen_r;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_meta_r <= 1'b0;
      lk_s_r    <= 1'b0;
    end else begin
      lk_meta_r <= locked;
      lk_s_r    <= lk_meta_r;
    end
  end

  // Lock-settle state machine with registered run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT;
      cnt_r   <= {CNT_W{1'b0}};
      run_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_WAIT: begin
          cnt_r   <= {CNT_W{1'b0}};
          run_r   <= 1'b0;
          state_r <= lk_s_r ? ST_SETTLE : ST_WAIT;
        end
        ST_SETTLE: begin
          if (!lk_s_r) begin
            state_r <= ST_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
            run_r   <= 1'b0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= ST_RUN;
            run_r   <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            run_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!lk_s_r) begin
            state_r <= ST_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
            run_r   <= 1'b0;
          end else begin
            run_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_WAIT;
          cnt_r   <= {CNT_W{1'b0}};
          run_r   <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel phase sum, carry and shadow-apply decision.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum_s[i]   = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
      carry_s[i] = active_s & sum_s[i][ACC_W];
      apply_s[i] = pend_r[i] & (carry_s[i] | ~run_st_s);
    end
  end

  // Accumulators, enable pulses and glitch-free increment update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc_r[i]    <= {ACC_W{1'b0}};
        inc_r[i]    <= INC_RST;
        shadow_r[i] <= {ACC_W{1'b0}};
      end
      pend_r <= {NCH{1'b0}};
      cen_r  <= {NCH{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (active_s) begin
          acc_r[i] <= sum_s[i][ACC_W-1:0];
        end else if (hold_s) begin
          acc_r[i] <= acc_r[i];
        end else begin
          acc_r[i] <= {ACC_W{1'b0}};
        end
        cen_r[i] <= carry_s[i];
        // Acceptance only happens with nothing pending, so it never meets an apply.
        if (accept_s && ch_ok_s && (cfg_ch == CH_W'(i))) begin
          shadow_r[i] <= cfg_inc;
          pend_r[i]   <= 1'b1;
        end else if (apply_s[i]) begin
          inc_r[i]    <= shadow_r[i];
          pend_r[i]   <= 1'b0;
        end else begin
          pend_r[i]   <= pend_r[i];
        end
      end
    end
  end

  // Ready tracks the pending set as it will stand after this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_r <= 1'b1;
    end else begin
      cfg_ready_r <= ~(accept_s & ch_ok_s) & ~(|(pend_r & ~apply_s));
    end
  end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Randomised bench for pll_cen_gen against a phase-crossing reference model.
module tb_pll_cen_gen;

  localparam int NCH = 3;
  localparam int W   = 16;
  localparam int LW  = 1024;
`ifdef PLL_CEN_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           locked;
  logic           pause;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [W-1:0]   cfg_inc;
  logic           run;
  logic [NCH-1:0] cen;

  int n_checks;
  int n_errors;

  // Reference model: pulses are counted as crossings of multiples of 2^W
  // by an unbounded running phase total.
  logic           m_s1, m_s2, m_run, m_ready;
  logic [NCH-1:0] m_cen, m_pend;
  int             m_streak;
  longint         m_t   [NCH];
  longint         m_inc [NCH];
  longint         m_sh  [NCH];

  pll_cen_gen #(
    .NCH(NCH), .CH_W(2), .ACC_W(W), .LOCK_WAIT(LW), .INC_RST(16'h2000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .pause(pause),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_inc(cfg_inc), .run(run), .cen(cen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic           act, hold;
    logic [NCH-1:0] cy;
    longint         nt;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_run = 1'b0; m_ready = 1'b1;
      m_cen = '0; m_pend = '0; m_streak = 0;
      for (int c = 0; c < NCH; c++) begin
        m_t[c] = 0; m_inc[c] = 64'h2000; m_sh[c] = 0;
      end
      return;
    end
    act  = m_run && m_s2 && !(PAUSE && pause);
    hold = m_run && m_s2 && PAUSE && pause;
    for (int c = 0; c < NCH; c++) begin
      nt    = m_t[c] + m_inc[c];
      cy[c] = act && ((nt >> W) != (m_t[c] >> W));
      if (act) m_t[c] = nt;
      else if (!hold) m_t[c] = 0;
    end
    m_cen = cy;
    for (int c = 0; c < NCH; c++) begin
      if (m_pend[c] && (cy[c] || !m_run)) begin
        m_inc[c]  = m_sh[c];
        m_pend[c] = 1'b0;
      end
    end
    if (cfg_valid && m_ready && int'(cfg_ch) < NCH) begin
      m_sh[cfg_ch]   = longint'(cfg_inc);
      m_pend[cfg_ch] = 1'b1;
    end
    m_ready  = (m_pend == '0);
    m_streak = m_s2 ? ((m_streak > LW) ? m_streak : m_streak + 1) : 0;
    m_run    = (m_streak >= LW + 1);
    m_s2     = m_s1;
    m_s1     = locked;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("run", 32'(run), 32'(m_run));
    chk("cen", 32'(cen), 32'(m_cen));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (!run && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_cen(input int ch, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!cen[ch] && n < 100);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!cfg_ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, cnt, consec;
    logic prev;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; locked = 1'b0; pause = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_inc = 16'h0000;
    repeat (3) tick();
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_cen", 32'(cen), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    repeat (5) tick();

    locked = 1'b1;
    wait_run(n);
    chk("start_latency", 32'(n), 32'd1027);
    wait_cen(0, n);
    chk("first_cen0", 32'(n), 32'd8);
    wait_cen(0, n);
    chk("period_cen0", 32'(n), 32'd8);

    // Rate change on ch1 from /8 to /2.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_inc = 16'h8000;
    tick();
    cfg_valid = 1'b0;
    chk("ready_drop", 32'(cfg_ready), 32'd0);
    wait_ready(n);
    chk("ready_back", 32'(cfg_ready), 32'd1);
    wait_cen(1, n);
    chk("new_period_a", 32'(n), 32'd2);
    wait_cen(1, n);
    chk("new_period_b", 32'(n), 32'd2);

    // Out-of-range channel is swallowed without blocking the port.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_inc = 16'h1234;
    tick();
    cfg_valid = 1'b0;
    chk("discard_ready", 32'(cfg_ready), 32'd1);

    // Long-run pulse density on ch2.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_inc = 16'h5556;
    tick();
    cfg_valid = 1'b0;
    wait_ready(n);
    cnt = 0; consec = 0; prev = 1'b0;
    for (int k = 0; k < 65536; k++) begin
      tick();
      if (cen[2]) begin
        cnt++;
        if (prev) consec++;
      end
      prev = cen[2];
    end
    chk("count_5556", 32'(cnt >= 21845 && cnt <= 21847), 32'd1);
    chk("no_back2back", 32'(consec), 32'd0);

    // One-cycle lock glitch while running.
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    tick();
    chk("loss_run", 32'(run), 32'd0);
    chk("loss_cen", 32'(cen), 32'd0);
    wait_run(n);
    chk("resettle_run", 32'(n), 32'd1025);

    // One-cycle lock glitch while settling restarts the full wait.
    locked = 1'b0;
    tick();
    locked = 1'b1;
    repeat (400) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_run(n);
    chk("resettle_settle", 32'(n), 32'd1027);

    // Random traffic on every input.
    for (int k = 0; k < 4000; k++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       cfg_inc = 16'h0000;
        1:       cfg_inc = 16'h8000;
        2:       cfg_inc = 16'hFFFF;
        default: cfg_inc = 16'($urandom);
      endcase
      pause  = ($urandom_range(0, 7) == 0);
      locked = ($urandom_range(0, 1499) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
